// File: rtl/prim_demux_fixed.sv
// Purpose: 1:N stream demultiplexer that steers each indexed transfer to one valid/ready output port.
// Latency: one cycle from input handshake to valid_o; sustains one transfer per cycle.
// Backpressure: ready_o follows the ready of the port being held; out-of-range beats are dropped and flagged on err_o.
module prim_demux_fixed #(
    parameter int N          = 8,
    parameter int DW         = 32,
    parameter bit EnDataPort = 1'b1,
    localparam int IdxW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [DW-1:0]   data_i,
    input  logic [IdxW-1:0] idx_i,
    output logic            ready_o,
    output logic [N-1:0]    valid_o,
    output logic [DW-1:0]   data_o,
    input  logic [N-1:0]    ready_i,
    output logic            err_o
);

    logic            full_q;
    logic            err_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] idx_load;
    logic            in_range;
    logic            drain;
    logic            accept;
    logic            load;
    logic            drop;

    // Decode the held index into per-port valids; idx_q never holds an index >= N.
    always_comb begin
        valid_o = '0;
        for (int k = 0; k < N; k++) begin
            valid_o[k] = full_q && (idx_q == IdxW'(k));
        end
    end

    // Only the ready of the selected port can retire the held beat.
    assign drain   = |(valid_o & ready_i);
    assign ready_o = ~full_q | drain;
    assign accept  = valid_i & ready_o;

    generate
        if (N == 1) begin : g_single
            // A single port: every index lands on port 0.
            logic unused_idx;
            assign unused_idx = ^idx_i;
            assign in_range   = 1'b1;
            assign idx_load   = '0;
        end else if (N == (1 << IdxW)) begin : g_pow2
            // Every encodable index names a real port.
            assign in_range = 1'b1;
            assign idx_load = idx_i;
        end else begin : g_range
            localparam logic [IdxW-1:0] MaxIdx = IdxW'(N - 1);
            assign in_range = (idx_i <= MaxIdx);
            assign idx_load = idx_i;
        end
    endgenerate

    assign load = accept & in_range;
    assign drop = accept & ~in_range;

    // Holding register control: a new beat overrides a same-cycle drain so throughput stays at one per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            full_q <= load | (full_q & ~drain);
            err_q  <= drop;
            if (load) begin
                idx_q <= idx_load;
            end
        end
    end

    generate
        if (EnDataPort) begin : g_data
            logic [DW-1:0] data_q;

            // Payload register loads only with an in-range beat and otherwise keeps its last value.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q <= '0;
                end else if (load) begin
                    data_q <= data_i;
                end
            end

            assign data_o = data_q;
        end else begin : g_nodata
            logic unused_data;
            assign unused_data = ^data_i;
            assign data_o      = '1;
        end
    endgenerate

    assign err_o = err_q;

    a_valid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(valid_o));

    a_valid_needs_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|valid_o) |-> full_q);

    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|(valid_o & ~ready_i)) |=> ($stable(valid_o) && $stable(data_o) && $stable(idx_q)));

    a_stall_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|(valid_o & ~ready_i)) |-> !ready_o);

    a_err_repeat: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (err_o && $past(err_o)) |-> ($past(drop) && $past(drop, 2)));

    a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({valid_o, ready_o, err_o}));

endmodule

// File: tb/tb_prim_demux_fixed.sv
module tb_prim_demux_fixed;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Stimulus per DUT: 0 -> N=8, 1 -> N=6, 2 -> N=1
    logic        va [3];
    logic [31:0] da [3];
    logic [2:0]  ia [3];
    logic [7:0]  ri [3];

    logic [7:0]  vo8;
    logic [5:0]  vo6;
    logic [0:0]  vo1;
    logic        ro8, ro6, ro1;
    logic        eo8, eo6, eo1;
    logic [31:0] do8, do6, do1;

    logic [7:0]  vo   [3];
    logic        ro   [3];
    logic        eo   [3];
    logic [31:0] dout [3];

    always_comb begin
        vo[0] = vo8;
        vo[1] = {2'b00, vo6};
        vo[2] = {7'b0000000, vo1};
        ro[0] = ro8;
        ro[1] = ro6;
        ro[2] = ro1;
        eo[0] = eo8;
        eo[1] = eo6;
        eo[2] = eo1;
        dout[0] = do8;
        dout[1] = do6;
        dout[2] = do1;
    end

    prim_demux_fixed #(.N(8), .DW(32), .EnDataPort(1'b1)) u_dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (va[0]),
        .data_i  (da[0]),
        .idx_i   (ia[0]),
        .ready_o (ro8),
        .valid_o (vo8),
        .data_o  (do8),
        .ready_i (ri[0]),
        .err_o   (eo8)
    );

    prim_demux_fixed #(.N(6), .DW(32), .EnDataPort(1'b1)) u_dut6 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (va[1]),
        .data_i  (da[1]),
        .idx_i   (ia[1]),
        .ready_o (ro6),
        .valid_o (vo6),
        .data_o  (do6),
        .ready_i (ri[1][5:0]),
        .err_o   (eo6)
    );

    prim_demux_fixed #(.N(1), .DW(32), .EnDataPort(1'b1)) u_dut1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (va[2]),
        .data_i  (da[2]),
        .idx_i   (ia[2][0]),
        .ready_o (ro1),
        .valid_o (vo1),
        .data_o  (do1),
        .ready_i (ri[2][0]),
        .err_o   (eo1)
    );

    // Expected response: either an error pulse or a beat for a port.
    typedef struct packed {
        logic        err;
        logic [2:0]  idx;
        logic [31:0] dat;
    } exp_t;

    exp_t sbq [3][$];
    int   ndel [3] = '{0, 0, 0};
    int   total = 0;
    int   bad   = 0;

    function automatic int nports(input int d);
        case (d)
            0:       return 8;
            1:       return 6;
            default: return 1;
        endcase
    endfunction

    function automatic bit idx_ok(input int d, input logic [2:0] idx);
        return (nports(d) == 1) || (int'(idx) < nports(d));
    endfunction

    function automatic int dest(input int d, input logic [2:0] idx);
        return (nports(d) == 1) ? 0 : int'(idx);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle against the head of the per-DUT expectation queue.
    bit         m_hb, m_he;
    int         m_p;
    logic [7:0] m_ev;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                sbq[d].delete();
                chk("rst_valid", d, 32'(vo[d]), 32'd0);
                chk("rst_err", d, 32'(eo[d]), 32'd0);
            end else begin
                m_hb = 1'b0;
                m_he = 1'b0;
                m_p  = 0;
                if (sbq[d].size() > 0) begin
                    m_hb = !sbq[d][0].err;
                    m_he = sbq[d][0].err;
                    m_p  = dest(d, sbq[d][0].idx);
                end
                m_ev = m_hb ? 8'(1 << m_p) : 8'h00;
                chk("valid_o", d, 32'(vo[d]), 32'(m_ev));
                chk("ready_o", d, 32'(ro[d]), m_hb ? 32'(ri[d][m_p]) : 32'd1);
                chk("err_o", d, 32'(eo[d]), 32'(m_he));
                if (m_hb) begin
                    chk("data_o", d, dout[d], sbq[d][0].dat);
                    if (ri[d][m_p]) begin
                        void'(sbq[d].pop_front());
                        ndel[d]++;
                    end
                end else if (m_he) begin
                    void'(sbq[d].pop_front());
                end
            end
        end
    end

    // One clock of stimulus: note which DUTs took a beat, and queue its expected outcome at the edge.
    task automatic step();
        bit   acc [3];
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 3; d++) acc[d] = va[d] && ro[d];
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (acc[d]) begin
                e.err = !idx_ok(d, ia[d]);
                e.idx = ia[d];
                e.dat = da[d];
                sbq[d].push_back(e);
            end
        end
        #1;
    endtask

    int n0;

    initial begin
        for (int d = 0; d < 3; d++) begin
            va[d] = 1'b0;
            da[d] = '0;
            ia[d] = '0;
            ri[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("init_valid", d, 32'(vo[d]), 32'd0);
            chk("init_ready", d, 32'(ro[d]), 32'd1);
            chk("init_err", d, 32'(eo[d]), 32'd0);
            chk("init_data", d, dout[d], 32'd0);
        end

        // Single beat to port 3
        va[0] = 1'b1; ia[0] = 3'd3; da[0] = 32'hDEAD_BEEF; ri[0] = 8'h08;
        step();
        va[0] = 1'b0;
        repeat (2) step();

        // Backpressure on port 5 with unrelated readies toggling, next beat waiting upstream
        va[0] = 1'b1; ia[0] = 3'd5; da[0] = 32'h0000_1234; ri[0] = 8'h00;
        step();
        ia[0] = 3'd1; da[0] = 32'h0000_0055;
        for (int k = 0; k < 4; k++) begin
            ri[0] = (k % 2 == 0) ? 8'h1F : 8'h0A;
            step();
        end
        ri[0] = 8'h20;
        step();
        va[0] = 1'b0; ri[0] = 8'h02;
        repeat (2) step();

        // Streaming: 16 back-to-back beats over all ports
        n0 = ndel[0];
        ri[0] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            va[0] = 1'b1; ia[0] = 3'(i % 8); da[0] = 32'hC0DE_0000 + 32'(i);
            step();
        end
        va[0] = 1'b0;
        step();
        chk("stream_count", 0, 32'(ndel[0] - n0), 32'd16);

        // N=6: out-of-range beat dropped
        va[1] = 1'b1; ia[1] = 3'd7; da[1] = 32'h0000_00AA; ri[1] = 8'hFF;
        step();
        va[1] = 1'b0;
        repeat (2) step();

        // N=6: out-of-range beat accepted while a held entry drains
        va[1] = 1'b1; ia[1] = 3'd2; da[1] = 32'h0000_0077; ri[1] = 8'h00;
        step();
        ia[1] = 3'd6; da[1] = 32'h0000_0099;
        step();
        ri[1] = 8'h04;
        step();
        va[1] = 1'b0;
        repeat (2) step();

        // N=1: any index goes to port 0
        ri[2] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            va[2] = 1'b1; ia[2] = 3'(7 - i); da[2] = 32'h1000_0000 + 32'(i);
            step();
        end
        va[2] = 1'b0;
        step();

        // Reset while holding a stalled entry
        va[0] = 1'b1; ia[0] = 3'd2; da[0] = 32'h0000_FACE; ri[0] = 8'h00;
        step();
        va[0] = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 0, 32'(vo[0]), 32'd0);
        chk("arst_data", 0, dout[0], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ri[0] = 8'hFF;
        repeat (3) step();

        // Randomized traffic on all three instances
        repeat (600) begin
            for (int d = 0; d < 3; d++) begin
                va[d] = ($urandom_range(0, 9) < 7);
                ia[d] = 3'($urandom_range(0, 7));
                da[d] = $urandom;
                ri[d] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            end
            step();
        end
        for (int d = 0; d < 3; d++) begin
            va[d] = 1'b0;
            ri[d] = 8'hFF;
        end
        repeat (4) step();
        for (int d = 0; d < 3; d++) begin
            chk("sb_empty", d, 32'(sbq[d].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
